// File: rtl/usb_proto_ctrl.sv
// -----------------------------------------------------------------------------
// usb_proto_ctrl
//
// Device-side USB transaction sequencer. It watches decoded packets from the
// receiver, decides which handshake or data packet to return, starts the
// transmitter, tracks the DATA0/DATA1 sequence bit and flushes the data buffer
// when a transfer completes or is aborted.
//
// Optional feature (macro USB_PROTO_TIMEOUT_EN): when defined, OUT_WAIT and
// WAIT_ACK give up after TIMEOUT_CYC cycles without a received packet and
// return to IDLE with a tx_error pulse. When undefined, they wait indefinitely.
//
// Parameters
//   TIMEOUT_CYC      cycles allowed for the host's DATA/ACK (timeout build only)
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   rx_done          1-cycle pulse at the end of each received packet
//   rx_packet[2:0]   received PID, valid with rx_done
//                    (101 IN, 110 OUT, 001 DATA, 010 ACK, 011 NACK)
//   rx_error         receiver error for the current packet (level)
//   buffer_occupancy bytes held in the data buffer, 0..64
//   host_ready       host has loaded the IN payload
//   tx_done          1-cycle pulse, transmitter finished
//   tx_start         1-cycle pulse, start transmission
//   tx_packet[2:0]   PID to send (000 none, 001 DATA, 010 ACK, 011 NAK)
//   d_mode           high while the device owns the bus
//   clear            1-cycle pulse, flush the data buffer
//   rx_data_ready    1-cycle pulse, OUT payload accepted
//   data_toggle      current DATA0/DATA1 sequence bit
//   tx_error         1-cycle pulse, transaction aborted
// -----------------------------------------------------------------------------
module usb_proto_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [2:0] rx_packet,
  input  logic       rx_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       host_ready,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [2:0] tx_packet,
  output logic       d_mode,
  output logic       clear,
  output logic       rx_data_ready,
  output logic       data_toggle,
  output logic       tx_error
);

  // Received PIDs
  localparam logic [2:0] PID_IN   = 3'b101;
  localparam logic [2:0] PID_OUT  = 3'b110;
  localparam logic [2:0] PID_DATA = 3'b001;
  localparam logic [2:0] PID_ACK  = 3'b010;
  localparam logic [2:0] PID_NACK = 3'b011;

  // Transmitted PIDs
  localparam logic [2:0] TX_NONE = 3'b000;
  localparam logic [2:0] TX_DATA = 3'b001;
  localparam logic [2:0] TX_ACK  = 3'b010;
  localparam logic [2:0] TX_NAK  = 3'b011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OUT_WAIT  = 3'd1,
    SEND_ACK  = 3'd2,
    SEND_NAK  = 3'd3,
    SEND_DATA = 3'd4,
    WAIT_ACK  = 3'd5
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;

  // Registered outputs and their next values
  logic       r_tx_start,      w_tx_start_nxt;
  logic [2:0] r_tx_packet,     w_tx_packet_nxt;
  logic       r_d_mode,        w_d_mode_nxt;
  logic       r_clear,         w_clear_nxt;
  logic       r_rx_data_ready, w_rx_data_ready_nxt;
  logic       r_data_toggle,   w_data_toggle_nxt;
  logic       r_tx_error,      w_tx_error_nxt;

  // Set once tx_start has been issued in the current SEND_* state; tx_done is
  // only honoured after that, so a stale pulse cannot end a send early.
  logic       r_sent,          w_sent_nxt;

  logic       w_timeout;

`ifdef USB_PROTO_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_to_cnt;
  logic             w_waiting;

  assign w_waiting = (r_state == OUT_WAIT) || (r_state == WAIT_ACK);

  // The entry cycle counts as cycle 0, so the abort edge falls after exactly
  // TIMEOUT_CYC cycles spent in the wait state.
  assign w_timeout = w_waiting && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      // Any state change restarts the count, which covers entry into both
      // wait states.
      r_to_cnt <= '0;
    end else if (w_waiting) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would infer a latch.
    w_state_nxt         = r_state;
    w_tx_start_nxt      = 1'b0;
    w_tx_packet_nxt     = r_tx_packet;
    w_d_mode_nxt        = r_d_mode;
    w_clear_nxt         = 1'b0;
    w_rx_data_ready_nxt = 1'b0;
    w_data_toggle_nxt   = r_data_toggle;
    w_tx_error_nxt      = 1'b0;
    w_sent_nxt          = r_sent;

    unique case (r_state)
      IDLE: begin
        // A corrupted token is dropped outright.
        if (rx_done && !rx_error) begin
          if (rx_packet == PID_OUT) begin
            w_state_nxt = OUT_WAIT;
          end else if (rx_packet == PID_IN) begin
            // d_mode is raised on the entry edge so it covers the whole state.
            w_d_mode_nxt = 1'b1;
            w_sent_nxt   = 1'b0;
            if (host_ready && (buffer_occupancy != 7'd0)) begin
              w_state_nxt = SEND_DATA;
            end else begin
              w_state_nxt = SEND_NAK;
            end
          end
        end
      end

      OUT_WAIT: begin
        if (rx_done) begin
          if (rx_error || (rx_packet != PID_DATA)) begin
            // Abort silently: flush whatever was received, no handshake.
            w_state_nxt    = IDLE;
            w_clear_nxt    = 1'b1;
            w_tx_error_nxt = 1'b1;
          end else begin
            w_state_nxt         = SEND_ACK;
            w_rx_data_ready_nxt = 1'b1;
            w_data_toggle_nxt   = ~r_data_toggle;
            w_d_mode_nxt        = 1'b1;
            w_sent_nxt          = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_nxt    = IDLE;
          w_clear_nxt    = 1'b1;
          w_tx_error_nxt = 1'b1;
        end
      end

      SEND_ACK, SEND_NAK, SEND_DATA: begin
        // Received packets are ignored while the device drives the bus.
        if (!r_sent) begin
          w_tx_start_nxt = 1'b1;
          w_sent_nxt     = 1'b1;
          if (r_state == SEND_ACK) begin
            w_tx_packet_nxt = TX_ACK;
          end else if (r_state == SEND_NAK) begin
            w_tx_packet_nxt = TX_NAK;
          end else begin
            w_tx_packet_nxt = TX_DATA;
          end
        end else if (tx_done) begin
          w_tx_packet_nxt = TX_NONE;
          w_d_mode_nxt    = 1'b0;
          w_sent_nxt      = 1'b0;
          w_state_nxt     = (r_state == SEND_DATA) ? WAIT_ACK : IDLE;
        end
      end

      WAIT_ACK: begin
        if (rx_done) begin
          w_state_nxt = IDLE;
          // Only a clean ACK completes the IN transfer; NACK, errors and any
          // unexpected PID keep the buffer and the toggle for a retry.
          if (!rx_error && (rx_packet == PID_ACK)) begin
            w_clear_nxt       = 1'b1;
            w_data_toggle_nxt = ~r_data_toggle;
          end
        end else if (w_timeout) begin
          w_state_nxt    = IDLE;
          w_tx_error_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_tx_packet_nxt = TX_NONE;
        w_d_mode_nxt    = 1'b0;
        w_sent_nxt      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_start      <= 1'b0;
      r_tx_packet     <= TX_NONE;
      r_d_mode        <= 1'b0;
      r_clear         <= 1'b0;
      r_rx_data_ready <= 1'b0;
      r_data_toggle   <= 1'b0;
      r_tx_error      <= 1'b0;
      r_sent          <= 1'b0;
    end else begin
      r_tx_start      <= w_tx_start_nxt;
      r_tx_packet     <= w_tx_packet_nxt;
      r_d_mode        <= w_d_mode_nxt;
      r_clear         <= w_clear_nxt;
      r_rx_data_ready <= w_rx_data_ready_nxt;
      r_data_toggle   <= w_data_toggle_nxt;
      r_tx_error      <= w_tx_error_nxt;
      r_sent          <= w_sent_nxt;
    end
  end

  assign tx_start      = r_tx_start;
  assign tx_packet     = r_tx_packet;
  assign d_mode        = r_d_mode;
  assign clear         = r_clear;
  assign rx_data_ready = r_rx_data_ready;
  assign data_toggle   = r_data_toggle;
  assign tx_error      = r_tx_error;

endmodule

// File: tb/tb_usb_proto_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_proto_ctrl
//
// Directed bench for usb_proto_ctrl. Inputs change and outputs are sampled on
// the falling clock edge. Every check compares the packed output vector
//   {tx_start, tx_packet[2:0], d_mode, clear, rx_data_ready, data_toggle,
//    tx_error}
// against a hand-computed constant. With USB_PROTO_TIMEOUT_EN defined the
// timeout behaviour is checked (TIMEOUT_CYC=16); otherwise the indefinite wait.
// -----------------------------------------------------------------------------
module tb_usb_proto_ctrl;

  localparam logic [2:0] PID_IN   = 3'b101;
  localparam logic [2:0] PID_OUT  = 3'b110;
  localparam logic [2:0] PID_DATA = 3'b001;
  localparam logic [2:0] PID_ACK  = 3'b010;
  localparam logic [2:0] PID_NACK = 3'b011;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [2:0] rx_packet;
  logic       rx_error;
  logic [6:0] buffer_occupancy;
  logic       host_ready;
  logic       tx_done;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic       d_mode;
  logic       clear;
  logic       rx_data_ready;
  logic       data_toggle;
  logic       tx_error;

  int total = 0;
  int bad   = 0;

  usb_proto_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_done          (rx_done),
    .rx_packet        (rx_packet),
    .rx_error         (rx_error),
    .buffer_occupancy (buffer_occupancy),
    .host_ready       (host_ready),
    .tx_done          (tx_done),
    .tx_start         (tx_start),
    .tx_packet        (tx_packet),
    .d_mode           (d_mode),
    .clear            (clear),
    .rx_data_ready    (rx_data_ready),
    .data_toggle      (data_toggle),
    .tx_error         (tx_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {tx_start, tx_packet, d_mode, clear, rx_data_ready, data_toggle, tx_error};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge, after the DUT
  // has sampled the pulse.
  task automatic rx_pulse(input logic [2:0] pid, input logic err);
    rx_done   = 1'b1;
    rx_packet = pid;
    rx_error  = err;
    step();
    rx_done   = 1'b0;
    rx_error  = 1'b0;
  endtask

  task automatic tx_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  //                            st pkt dm cl rdy tg er
  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_packet = 3'b000; rx_error = 1'b0;
    buffer_occupancy = 7'd0; host_ready = 1'b0; tx_done = 1'b0;
    step(); step();
    check("reset", 9'b0_000_0_0_0_0_0);
    rst = 1'b0;
    step();

    // IN with host not ready -> NAK, toggle unchanged
    rx_pulse(PID_IN, 1'b0);
    check("nak_entry",   9'b0_000_1_0_0_0_0);
    step();
    check("nak_start",   9'b1_011_1_0_0_0_0);
    step();
    check("nak_hold",    9'b0_011_1_0_0_0_0);
    tx_pulse();
    check("nak_done",    9'b0_000_0_0_0_0_0);

    // OUT then clean DATA -> ACK, toggle 0->1
    rx_pulse(PID_OUT, 1'b0);
    check("out_wait",    9'b0_000_0_0_0_0_0);
    rx_pulse(PID_DATA, 1'b0);
    check("out_data",    9'b0_000_1_0_1_1_0);
    step();
    check("ack_start",   9'b1_010_1_0_0_1_0);
    rx_pulse(PID_IN, 1'b0);
    check("ack_ign_rx",  9'b0_010_1_0_0_1_0);
    tx_pulse();
    check("ack_done",    9'b0_000_0_0_0_1_0);

    // Reset in the middle of SEND_DATA, then a stray tx_done
    host_ready = 1'b1; buffer_occupancy = 7'd8;
    rx_pulse(PID_IN, 1'b0);
    check("rst_entry",   9'b0_000_1_0_0_1_0);
    step();
    check("rst_start",   9'b1_001_1_0_0_1_0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid",     9'b0_000_0_0_0_0_0);
    tx_pulse();
    check("rst_txdone",  9'b0_000_0_0_0_0_0);
    step();
    check("rst_idle",    9'b0_000_0_0_0_0_0);

    // IN serviced then ACK -> DATA, clear, toggle 0->1
    rx_pulse(PID_IN, 1'b0);
    check("in_entry",    9'b0_000_1_0_0_0_0);
    step();
    check("in_start",    9'b1_001_1_0_0_0_0);
    tx_pulse();
    check("in_txdone",   9'b0_000_0_0_0_0_0);
    rx_pulse(PID_ACK, 1'b0);
    check("in_ack",      9'b0_000_0_1_0_1_0);
    step();
    check("in_ack_end",  9'b0_000_0_0_0_1_0);

    // Empty buffer with host ready -> NAK
    buffer_occupancy = 7'd0;
    rx_pulse(PID_IN, 1'b0);
    step();
    check("empty_nak",   9'b1_011_1_0_0_1_0);
    tx_pulse();
    check("empty_done",  9'b0_000_0_0_0_1_0);

    // Full buffer, host answers NACK -> buffer kept, toggle unchanged
    buffer_occupancy = 7'd64;
    rx_pulse(PID_IN, 1'b0);
    step();
    check("full_start",  9'b1_001_1_0_0_1_0);
    tx_pulse();
    rx_pulse(PID_NACK, 1'b0);
    check("nack",        9'b0_000_0_0_0_1_0);

    // OUT then DATA with rx_error -> abort
    rx_pulse(PID_OUT, 1'b0);
    check("err_owait",   9'b0_000_0_0_0_1_0);
    rx_pulse(PID_DATA, 1'b1);
    check("err_data",    9'b0_000_0_1_0_1_1);
    step();
    check("err_no_tx",   9'b0_000_0_0_0_1_0);

    // OUT then a non-DATA PID -> abort
    rx_pulse(PID_OUT, 1'b0);
    rx_pulse(PID_ACK, 1'b0);
    check("out_bad_pid", 9'b0_000_0_1_0_1_1);

    // Errored IN token in IDLE is dropped; tx_done in IDLE ignored
    buffer_occupancy = 7'd8;
    rx_pulse(PID_IN, 1'b1);
    check("idle_err",    9'b0_000_0_0_0_1_0);
    step();
    check("idle_err_nx", 9'b0_000_0_0_0_1_0);
    tx_pulse();
    check("idle_txdone", 9'b0_000_0_0_0_1_0);

    // ACK with rx_error in WAIT_ACK -> no clear, toggle unchanged
    rx_pulse(PID_IN, 1'b0);
    step();
    tx_pulse();
    rx_pulse(PID_ACK, 1'b1);
    check("wack_err",    9'b0_000_0_0_0_1_0);

    // Wait-state behaviour with no host response
    rx_pulse(PID_IN, 1'b0);
    step();
    tx_pulse();
`ifdef USB_PROTO_TIMEOUT_EN
    repeat (15) step();
    check("wack_pre_to", 9'b0_000_0_0_0_1_0);
    step();
    check("wack_to",     9'b0_000_0_0_0_1_1);
    step();
    check("wack_to_end", 9'b0_000_0_0_0_1_0);
    rx_pulse(PID_OUT, 1'b0);
    repeat (15) step();
    check("owait_pre",   9'b0_000_0_0_0_1_0);
    step();
    check("owait_to",    9'b0_000_0_1_0_1_1);
    rx_pulse(PID_OUT, 1'b0);
    rx_pulse(PID_DATA, 1'b0);
    check("late_data",   9'b0_000_1_0_1_0_0);
`else
    repeat (40) step();
    check("wack_wait",   9'b0_000_0_0_0_1_0);
    rx_pulse(PID_ACK, 1'b0);
    check("wack_late",   9'b0_000_0_1_0_0_0);
    rx_pulse(PID_OUT, 1'b0);
    repeat (40) step();
    check("owait_wait",  9'b0_000_0_0_0_0_0);
    rx_pulse(PID_DATA, 1'b0);
    check("late_data",   9'b0_000_1_0_1_1_0);
`endif
    step();
    tx_pulse();
    check("final_idle",  {8'b0_000_0_0_0_0, 1'b0} | {7'b0, data_toggle_exp(), 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Expected toggle at the end of the run for the selected build.
  function automatic logic data_toggle_exp();
`ifdef USB_PROTO_TIMEOUT_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

endmodule
